// File: rtl/oculink_port_mgr_if.sv
// Per-port OCuLink sideband bundle between the board pins / VIO / PCIe cores
// and the port manager. Every vector carries one bit (or field) per port.
//   cprsnt          raw presence pins (asynchronous)
//   user_lnk_up     link-up from each PCIe core
//   finished_config configurator done (level)
//   failed_config   configurator failed (level)
//   force_perst     manual PERST# override
//   restart         pulse that releases a port from FAIL
//   perst_n         PERST# to the connector, active-low
//   start_config    single-cycle configurator kick
//   port_up         port fully up
//   port_state      3-bit state code per port
//   retry_cnt       4-bit failure count per port
// slave is the manager side, master is the board/system side.
interface oculink_port_mgr_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]   cprsnt;
  logic [NUM_PORTS-1:0]   user_lnk_up;
  logic [NUM_PORTS-1:0]   finished_config;
  logic [NUM_PORTS-1:0]   failed_config;
  logic [NUM_PORTS-1:0]   force_perst;
  logic [NUM_PORTS-1:0]   restart;
  logic [NUM_PORTS-1:0]   perst_n;
  logic [NUM_PORTS-1:0]   start_config;
  logic [NUM_PORTS-1:0]   port_up;
  logic [3*NUM_PORTS-1:0] port_state;
  logic [4*NUM_PORTS-1:0] retry_cnt;

  modport slave (
    input  cprsnt, user_lnk_up, finished_config, failed_config, force_perst, restart,
    output perst_n, start_config, port_up, port_state, retry_cnt
  );

  modport master (
    output cprsnt, user_lnk_up, finished_config, failed_config, force_perst, restart,
    input  perst_n, start_config, port_up, port_state, retry_cnt
  );
endinterface

// File: rtl/oculink_port_mgr.sv
// Root-port OCuLink bring-up sequencer: one independent FSM per port that
// debounces card presence, holds PERST#, waits for link-up with timeout and
// retry, kicks the configurator and reports status.
// Ports:
//   user_clk  sole clock, rising edge
//   reset     synchronous, active-high
//   bus       oculink_port_mgr_if.slave, per-port sideband bundle
//
// state      | code | meaning
// IDLE       | 0    | no card, or waiting for presence
// DEBOUNCE   | 1    | card seen, counting stable-present cycles
// PERST_HOLD | 2    | PERST# asserted for a fixed time
// WAIT_LINK  | 3    | PERST# released, waiting for user_lnk_up
// CONFIG     | 4    | configurator kicked, waiting for done/fail
// UP         | 5    | link up and configured
// FAIL       | 6    | retries exhausted, waiting for restart
// FORCED     | 7    | PERST# forced by force_perst
module oculink_port_mgr #(
  parameter int NUM_PORTS         = 2,
  parameter int CNT_W             = 24,
  parameter int DEBOUNCE_CYC      = 1000000,
  parameter int PERST_CYC         = 250000,
  parameter int LINK_TIMEOUT_CYC  = 12500000,
  parameter int MAX_RETRY         = 3,
  parameter int CPRSNT_ACTIVE_LOW = 1
) (
  input logic               user_clk,
  input logic               reset,
  oculink_port_mgr_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DEBOUNCE   = 3'd1,
    PERST_HOLD = 3'd2,
    WAIT_LINK  = 3'd3,
    CONFIG     = 3'd4,
    UP         = 3'd5,
    FAIL       = 3'd6,
    FORCED     = 3'd7
  } state_t;

  // Timers count down from CYC-1 loaded on entry; terminal count is zero.
  localparam logic [CNT_W-1:0] LD_DEB   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PERST = CNT_W'(PERST_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LINK  = CNT_W'(LINK_TIMEOUT_CYC - 1);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);
  // Pin level meaning "no card"; also the synchroniser reset value so a
  // port never sees a phantom card right after reset.
  localparam logic             ABSENT   = (CPRSNT_ACTIVE_LOW != 0);

  function automatic logic [CNT_W-1:0] load_for(state_t s);
    case (s)
      DEBOUNCE:   return LD_DEB;
      PERST_HOLD: return LD_PERST;
      WAIT_LINK:  return LD_LINK;
      default:    return '0;
    endcase
  endfunction

  logic [NUM_PORTS-1:0]   perst_v;
  logic [NUM_PORTS-1:0]   start_v;
  logic [NUM_PORTS-1:0]   up_v;
  logic [3*NUM_PORTS-1:0] state_v;
  logic [4*NUM_PORTS-1:0] retry_v;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [1:0]       sync_q;
    logic             present_s;
    logic             tc;
    logic             fail_ev;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q;
    logic [3:0]       retry_q, retry_d, retry_inc;
    logic             perst_q, start_q, up_q;

    assign present_s = sync_q[1] ^ ABSENT;
    assign tc        = (timer_q == '0);
    assign retry_inc = (retry_q == 4'hf) ? retry_q : retry_q + 4'd1;

    always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      fail_ev = 1'b0;
      if (bus.force_perst[i]) begin
        state_d = FORCED;
      end else if (state_q == FORCED) begin
        state_d = IDLE;
      end else if (!present_s) begin
        state_d = IDLE;
        retry_d = '0;
      end else begin
        case (state_q)
          IDLE:       state_d = DEBOUNCE;
          DEBOUNCE:   if (tc) state_d = PERST_HOLD;
          PERST_HOLD: if (tc) state_d = WAIT_LINK;
          WAIT_LINK: begin
            if (bus.user_lnk_up[i]) state_d = CONFIG;
            else if (tc)            fail_ev = 1'b1;
          end
          // Link drop and failed_config both outrank finished_config.
          CONFIG: begin
            if (!bus.user_lnk_up[i] || bus.failed_config[i]) fail_ev = 1'b1;
            else if (bus.finished_config[i])                 state_d = UP;
          end
          UP:         if (!bus.user_lnk_up[i]) state_d = PERST_HOLD;
          FAIL: begin
            if (bus.restart[i]) begin
              state_d = IDLE;
              retry_d = '0;
            end
          end
          default:    state_d = IDLE;
        endcase
        if (fail_ev) begin
          retry_d = retry_inc;
          state_d = (retry_inc >= RETRY_LIM) ? FAIL : PERST_HOLD;
        end
        if (state_d == UP && state_q != UP) retry_d = '0;
      end
    end

    always_ff @(posedge user_clk) begin
      if (reset) begin
        sync_q  <= {2{ABSENT}};
        state_q <= IDLE;
        timer_q <= '0;
        retry_q <= '0;
        perst_q <= 1'b0;
        start_q <= 1'b0;
        up_q    <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], bus.cprsnt[i]};
        state_q <= state_d;
        retry_q <= retry_d;
        if (state_d != state_q) timer_q <= load_for(state_d);
        else if (!tc)           timer_q <= timer_q - 1'b1;
        // Outputs registered from the next state so they line up with state_q.
        perst_q <= (state_d inside {WAIT_LINK, CONFIG, UP});
        start_q <= (state_d == CONFIG) && (state_q != CONFIG);
        up_q    <= (state_d == UP);
      end
    end

    assign perst_v[i]         = perst_q;
    assign start_v[i]         = start_q;
    assign up_v[i]            = up_q;
    assign state_v[3*i +: 3]  = state_q;
    assign retry_v[4*i +: 4]  = retry_q;
  end

  assign bus.perst_n      = perst_v;
  assign bus.start_config = start_v;
  assign bus.port_up      = up_v;
  assign bus.port_state   = state_v;
  assign bus.retry_cnt    = retry_v;

endmodule

// File: tb/tb_oculink_port_mgr.sv
// Directed bench for oculink_port_mgr with D=4, P=8, T=16, MAX_RETRY=2,
// active-low presence, two ports. Times are counted in clock edges after the
// presence pin is driven (reference edge k).
module tb_oculink_port_mgr;
  localparam int NP = 2;

  logic user_clk = 1'b0;
  logic reset    = 1'b1;
  int   cyc      = 0;
  int   k        = 0;
  int   n_pass   = 0;
  int   n_total  = 0;

  oculink_port_mgr_if #(.NUM_PORTS(NP)) bus ();

  oculink_port_mgr #(
    .NUM_PORTS(NP), .CNT_W(8), .DEBOUNCE_CYC(4), .PERST_CYC(8),
    .LINK_TIMEOUT_CYC(16), .MAX_RETRY(2), .CPRSNT_ACTIVE_LOW(1)
  ) dut (
    .user_clk(user_clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 user_clk = ~user_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge user_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic idle_inputs();
    bus.cprsnt          = '1;
    bus.user_lnk_up     = '0;
    bus.finished_config = '0;
    bus.failed_config   = '0;
    bus.force_perst     = '0;
    bus.restart         = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    k = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cprsnt = '0; bus.user_lnk_up = '1; bus.finished_config = '1;
    tick(); tick(); tick();
    n_total++; if (bus.perst_n !== 2'b00) $display("FAIL rst_perst: got %b expected 00", bus.perst_n); else n_pass++;
    n_total++; if (bus.start_config !== 2'b00) $display("FAIL rst_start: got %b expected 00", bus.start_config); else n_pass++;
    n_total++; if (bus.port_up !== 2'b00) $display("FAIL rst_up: got %b expected 00", bus.port_up); else n_pass++;
    n_total++; if (bus.port_state !== 6'd0) $display("FAIL rst_state: got %h expected 0", bus.port_state); else n_pass++;
    n_total++; if (bus.retry_cnt !== 8'd0) $display("FAIL rst_retry: got %h expected 0", bus.retry_cnt); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.cprsnt = 2'b10;
    run_to(k + 14);
    n_total++; if (bus.perst_n[0] !== 1'b0) $display("FAIL to_perst_pre: got %b expected 0", bus.perst_n[0]); else n_pass++;
    n_total++; if (bus.port_state[2:0] !== 3'd2) $display("FAIL to_state_hold: got %0d expected 2", bus.port_state[2:0]); else n_pass++;
    run_to(k + 15);
    n_total++; if (bus.perst_n[0] !== 1'b1) $display("FAIL to_perst_rise: got %b expected 1", bus.perst_n[0]); else n_pass++;
    n_total++; if (bus.port_state[2:0] !== 3'd3) $display("FAIL to_state_wait: got %0d expected 3", bus.port_state[2:0]); else n_pass++;
    run_to(k + 30);
    n_total++; if (bus.port_state[2:0] !== 3'd3) $display("FAIL to_state_wait_end: got %0d expected 3", bus.port_state[2:0]); else n_pass++;
    run_to(k + 31);
    n_total++; if (bus.port_state[2:0] !== 3'd2) $display("FAIL to_state_retry: got %0d expected 2", bus.port_state[2:0]); else n_pass++;
    n_total++; if (bus.retry_cnt[3:0] !== 4'd1) $display("FAIL to_retry1: got %0d expected 1", bus.retry_cnt[3:0]); else n_pass++;
    n_total++; if (bus.perst_n[0] !== 1'b0) $display("FAIL to_perst_retry: got %b expected 0", bus.perst_n[0]); else n_pass++;
    run_to(k + 55);
    n_total++; if (bus.port_state[2:0] !== 3'd6) $display("FAIL to_state_fail: got %0d expected 6", bus.port_state[2:0]); else n_pass++;
    n_total++; if (bus.perst_n[0] !== 1'b0) $display("FAIL to_perst_fail: got %b expected 0", bus.perst_n[0]); else n_pass++;
    n_total++; if (bus.retry_cnt[3:0] !== 4'd2) $display("FAIL to_retry2: got %0d expected 2", bus.retry_cnt[3:0]); else n_pass++;
    n_total++; if (bus.port_state[5:3] !== 3'd0) $display("FAIL to_port1_idle: got %0d expected 0", bus.port_state[5:3]); else n_pass++;
  endtask

  task automatic test_restart();
    do_reset();
    bus.cprsnt = 2'b10;
    run_to(k + 56);
    n_total++; if (bus.port_state[2:0] !== 3'd6) $display("FAIL rs_in_fail: got %0d expected 6", bus.port_state[2:0]); else n_pass++;
    bus.restart = 2'b01;
    tick();
    bus.restart = 2'b00;
    n_total++; if (bus.port_state[2:0] !== 3'd0) $display("FAIL rs_idle: got %0d expected 0", bus.port_state[2:0]); else n_pass++;
    n_total++; if (bus.retry_cnt[3:0] !== 4'd0) $display("FAIL rs_retry_clr: got %0d expected 0", bus.retry_cnt[3:0]); else n_pass++;
    tick();
    n_total++; if (bus.port_state[2:0] !== 3'd1) $display("FAIL rs_debounce: got %0d expected 1", bus.port_state[2:0]); else n_pass++;
    bus.restart = 2'b01;
    tick();
    bus.restart = 2'b00;
    n_total++; if (bus.port_state[2:0] !== 3'd1) $display("FAIL rs_ignored: got %0d expected 1", bus.port_state[2:0]); else n_pass++;
  endtask

  task automatic test_bringup();
    do_reset();
    bus.cprsnt = 2'b10;
    run_to(k + 20);
    n_total++; if (bus.port_state[2:0] !== 3'd3) $display("FAIL bu_wait: got %0d expected 3", bus.port_state[2:0]); else n_pass++;
    bus.user_lnk_up = 2'b01;
    tick();
    n_total++; if (bus.port_state[2:0] !== 3'd4) $display("FAIL bu_config: got %0d expected 4", bus.port_state[2:0]); else n_pass++;
    n_total++; if (bus.start_config[0] !== 1'b1) $display("FAIL bu_start_hi: got %b expected 1", bus.start_config[0]); else n_pass++;
    tick();
    n_total++; if (bus.start_config[0] !== 1'b0) $display("FAIL bu_start_lo: got %b expected 0", bus.start_config[0]); else n_pass++;
    n_total++; if (bus.port_state[2:0] !== 3'd4) $display("FAIL bu_config_hold: got %0d expected 4", bus.port_state[2:0]); else n_pass++;
    bus.finished_config = 2'b01;
    tick();
    n_total++; if (bus.port_state[2:0] !== 3'd5) $display("FAIL bu_up_state: got %0d expected 5", bus.port_state[2:0]); else n_pass++;
    n_total++; if (bus.port_up[0] !== 1'b1) $display("FAIL bu_port_up: got %b expected 1", bus.port_up[0]); else n_pass++;
    bus.user_lnk_up = 2'b00;
    bus.finished_config = 2'b00;
    tick();
    n_total++; if (bus.port_state[2:0] !== 3'd2) $display("FAIL bu_drop_hold: got %0d expected 2", bus.port_state[2:0]); else n_pass++;
    n_total++; if (bus.port_up[0] !== 1'b0) $display("FAIL bu_drop_up: got %b expected 0", bus.port_up[0]); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++; if (bus.perst_n[0] !== 1'b0) $display("FAIL bu_hold_perst cyc%0d: got %b expected 0", i, bus.perst_n[0]); else n_pass++;
      tick();
    end
    n_total++; if (bus.port_state[2:0] !== 3'd3) $display("FAIL bu_rewait: got %0d expected 3", bus.port_state[2:0]); else n_pass++;
    n_total++; if (bus.perst_n[0] !== 1'b1) $display("FAIL bu_reperst: got %b expected 1", bus.perst_n[0]); else n_pass++;
    n_total++; if (bus.retry_cnt[3:0] !== 4'd0) $display("FAIL bu_retry: got %0d expected 0", bus.retry_cnt[3:0]); else n_pass++;
  endtask

  task automatic test_glitch();
    logic saw_deb;
    logic bad;
    saw_deb = 1'b0;
    bad = 1'b0;
    do_reset();
    bus.cprsnt = 2'b10;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cyc == k + 3) bus.cprsnt = 2'b11;
      if (bus.port_state[2:0] == 3'd1) saw_deb = 1'b1;
      if (bus.port_state[2:0] > 3'd1 || bus.perst_n[0] !== 1'b0) bad = 1'b1;
    end
    n_total++; if (saw_deb !== 1'b1) $display("FAIL gl_saw_debounce: got %b expected 1", saw_deb); else n_pass++;
    n_total++; if (bad !== 1'b0) $display("FAIL gl_left_debounce: got %b expected 0", bad); else n_pass++;
    n_total++; if (bus.port_state[2:0] !== 3'd0) $display("FAIL gl_idle: got %0d expected 0", bus.port_state[2:0]); else n_pass++;
  endtask

  task automatic test_removal();
    do_reset();
    bus.cprsnt = 2'b10;
    bus.user_lnk_up = 2'b01;
    bus.finished_config = 2'b01;
    run_to(k + 16);
    n_total++; if (bus.start_config[0] !== 1'b1) $display("FAIL rm_start: got %b expected 1", bus.start_config[0]); else n_pass++;
    run_to(k + 17);
    n_total++; if (bus.port_up[0] !== 1'b1) $display("FAIL rm_up: got %b expected 1", bus.port_up[0]); else n_pass++;
    run_to(k + 20);
    bus.cprsnt = 2'b11;
    run_to(k + 22);
    n_total++; if (bus.port_state[2:0] !== 3'd5) $display("FAIL rm_still_up: got %0d expected 5", bus.port_state[2:0]); else n_pass++;
    run_to(k + 23);
    n_total++; if (bus.port_state[2:0] !== 3'd0) $display("FAIL rm_idle: got %0d expected 0", bus.port_state[2:0]); else n_pass++;
    n_total++; if (bus.perst_n[0] !== 1'b0) $display("FAIL rm_perst: got %b expected 0", bus.perst_n[0]); else n_pass++;
    n_total++; if (bus.port_up[0] !== 1'b0) $display("FAIL rm_port_up: got %b expected 0", bus.port_up[0]); else n_pass++;
  endtask

  task automatic test_config_fail();
    do_reset();
    bus.cprsnt = 2'b10;
    bus.user_lnk_up = 2'b01;
    bus.finished_config = 2'b01;
    bus.failed_config = 2'b01;
    run_to(k + 16);
    n_total++; if (bus.port_state[2:0] !== 3'd4) $display("FAIL cf_both_config: got %0d expected 4", bus.port_state[2:0]); else n_pass++;
    run_to(k + 17);
    n_total++; if (bus.port_state[2:0] !== 3'd2) $display("FAIL cf_both_state: got %0d expected 2", bus.port_state[2:0]); else n_pass++;
    n_total++; if (bus.retry_cnt[3:0] !== 4'd1) $display("FAIL cf_both_retry: got %0d expected 1", bus.retry_cnt[3:0]); else n_pass++;
    do_reset();
    bus.cprsnt = 2'b10;
    bus.user_lnk_up = 2'b01;
    run_to(k + 16);
    n_total++; if (bus.port_state[2:0] !== 3'd4) $display("FAIL cf_drop_config: got %0d expected 4", bus.port_state[2:0]); else n_pass++;
    bus.user_lnk_up = 2'b00;
    bus.finished_config = 2'b01;
    tick();
    n_total++; if (bus.port_state[2:0] !== 3'd2) $display("FAIL cf_drop_state: got %0d expected 2", bus.port_state[2:0]); else n_pass++;
    n_total++; if (bus.retry_cnt[3:0] !== 4'd1) $display("FAIL cf_drop_retry: got %0d expected 1", bus.retry_cnt[3:0]); else n_pass++;
  endtask

  task automatic test_force();
    do_reset();
    bus.cprsnt = 2'b10;
    run_to(k + 17);
    n_total++; if (bus.port_state[2:0] !== 3'd3) $display("FAIL fp_wait: got %0d expected 3", bus.port_state[2:0]); else n_pass++;
    bus.force_perst = 2'b01;
    tick();
    n_total++; if (bus.port_state[2:0] !== 3'd7) $display("FAIL fp_forced: got %0d expected 7", bus.port_state[2:0]); else n_pass++;
    n_total++; if (bus.perst_n[0] !== 1'b0) $display("FAIL fp_perst: got %b expected 0", bus.perst_n[0]); else n_pass++;
    tick();
    bus.force_perst = 2'b00;
    tick();
    n_total++; if (bus.port_state[2:0] !== 3'd0) $display("FAIL fp_release_idle: got %0d expected 0", bus.port_state[2:0]); else n_pass++;
    run_to(k + 21);
    n_total++; if (bus.port_state[2:0] !== 3'd1) $display("FAIL fp_redebounce: got %0d expected 1", bus.port_state[2:0]); else n_pass++;
    run_to(k + 25);
    n_total++; if (bus.port_state[2:0] !== 3'd2) $display("FAIL fp_rehold: got %0d expected 2", bus.port_state[2:0]); else n_pass++;
    run_to(k + 33);
    n_total++; if (bus.perst_n[0] !== 1'b1) $display("FAIL fp_reperst: got %b expected 1", bus.perst_n[0]); else n_pass++;
  endtask

  task automatic test_independent();
    do_reset();
    bus.cprsnt = 2'b00;
    bus.user_lnk_up = 2'b01;
    bus.finished_config = 2'b01;
    run_to(k + 55);
    n_total++; if (bus.port_state !== 6'b110_101) $display("FAIL ind_state: got %b expected 110101", bus.port_state); else n_pass++;
    n_total++; if (bus.port_up !== 2'b01) $display("FAIL ind_up: got %b expected 01", bus.port_up); else n_pass++;
    n_total++; if (bus.perst_n !== 2'b01) $display("FAIL ind_perst: got %b expected 01", bus.perst_n); else n_pass++;
    n_total++; if (bus.retry_cnt !== 8'h20) $display("FAIL ind_retry: got %h expected 20", bus.retry_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.cprsnt = 2'b00;
    bus.user_lnk_up = 2'b11;
    run_to(k + 16);
    n_total++; if (bus.port_state !== 6'b100_100) $display("FAIL rm_cfg_state: got %b expected 100100", bus.port_state); else n_pass++;
    n_total++; if (bus.start_config !== 2'b11) $display("FAIL rm_cfg_start: got %b expected 11", bus.start_config); else n_pass++;
    reset = 1'b1;
    tick();
    n_total++; if (bus.port_state !== 6'd0) $display("FAIL mid_state: got %b expected 0", bus.port_state); else n_pass++;
    n_total++; if (bus.perst_n !== 2'b00) $display("FAIL mid_perst: got %b expected 00", bus.perst_n); else n_pass++;
    n_total++; if (bus.start_config !== 2'b00) $display("FAIL mid_start: got %b expected 00", bus.start_config); else n_pass++;
    n_total++; if (bus.port_up !== 2'b00) $display("FAIL mid_up: got %b expected 00", bus.port_up); else n_pass++;
    n_total++; if (bus.retry_cnt !== 8'd0) $display("FAIL mid_retry: got %h expected 0", bus.retry_cnt); else n_pass++;
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_timeout();
    test_restart();
    test_bringup();
    test_glitch();
    test_removal();
    test_config_fail();
    test_force();
    test_independent();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
